// File: rtl/risc_fetch_stage.sv
// risc_fetch_stage: RV32I fetch front end; owns the PC, issues credit-limited word requests,
// buffers in-order responses and hands {pc, instr} to decode, with redirect flush.
module risc_fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req_valid,
    output logic [31:0]                   imem_req_addr,
    input  logic                          imem_req_ready,
    input  logic                          imem_rsp_valid,
    input  logic [31:0]                   imem_rsp_data,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          dec_valid,
    input  logic                          dec_ready,
    output logic [31:0]                   dec_instr,
    output logic [31:0]                   dec_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] L_MAXO  = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] L_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   L_DEPTH = (CW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] L_SLAST = SW'(MAX_OUTSTANDING - 1);

    logic [31:0]   r_pc;
    logic          r_run;
    logic [CW-1:0] r_out, r_drop, r_cnt;
    logic [AW-1:0] r_wp, r_rp;
    logic [SW-1:0] r_swp, r_srp;
    logic [31:0]   r_sh_addr [MAX_OUTSTANDING];
    logic [31:0]   r_f_pc    [FIFO_DEPTH];
    logic [31:0]   r_f_instr [FIFO_DEPTH];
    logic          w_req_fire, w_rsp_keep, w_rsp_drop, w_push, w_pop, w_unused;
    logic [CW:0]   w_used;
    logic [SW-1:0] w_swp_nx, w_srp_nx;

    // Credits: fifo entries plus in-flight requests never exceed the buffer depth.
    assign w_used         = {1'b0, r_cnt} + {1'b0, r_out};
    assign imem_req_valid = r_run && (r_out < L_MAXO) && (w_used < L_DEPTH) && !redirect_valid;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_keep     = imem_rsp_valid && (r_drop == '0);
    assign w_rsp_drop     = imem_rsp_valid && (r_drop != '0);
    assign w_push         = w_rsp_keep && !redirect_valid;
    assign dec_valid      = r_cnt != '0;
    assign w_pop          = dec_valid && dec_ready && !redirect_valid;
    assign dec_instr      = dec_valid ? r_f_instr[r_rp] : '0;
    assign dec_pc         = dec_valid ? r_f_pc[r_rp] : '0;
    assign fifo_count     = r_cnt;
    assign w_swp_nx       = (r_swp == L_SLAST) ? '0 : r_swp + SW'(1);
    assign w_srp_nx       = (r_srp == L_SLAST) ? '0 : r_srp + SW'(1);
    assign w_unused       = ^redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc   <= RESET_PC;
            r_run  <= 1'b0;
            r_out  <= '0;
            r_drop <= '0;
            r_cnt  <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_swp  <= '0;
            r_srp  <= '0;
        end else begin
            r_run  <= 1'b1;
            r_out  <= r_out + CW'(w_req_fire) - CW'(imem_rsp_valid);
            r_drop <= redirect_valid ? r_out - CW'(imem_rsp_valid) : r_drop - CW'(w_rsp_drop);
            r_cnt  <= redirect_valid ? '0 : r_cnt + CW'(w_push) - CW'(w_pop);
            r_pc   <= redirect_valid ? {redirect_pc[31:2], 2'b00} : w_req_fire ? r_pc + 32'd4 : r_pc;
            r_wp   <= redirect_valid ? '0 : r_wp + AW'(w_push);
            r_rp   <= redirect_valid ? '0 : r_rp + AW'(w_pop);
            r_swp  <= redirect_valid ? '0 : w_req_fire ? w_swp_nx : r_swp;
            // Dropped responses never had a live shadow entry, so only kept ones advance the read side.
            r_srp  <= redirect_valid ? '0 : w_rsp_keep ? w_srp_nx : r_srp;
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire)
            r_sh_addr[r_swp] <= r_pc;
        if (w_push) begin
            r_f_pc[r_wp]    <= r_sh_addr[r_srp];
            r_f_instr[r_wp] <= imem_rsp_data;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            assert (!(imem_rsp_valid && r_out == '0)) else $error("response with no outstanding request");
            assert (!(w_push && r_cnt == L_FULL)) else $error("instruction buffer overflow");
        end
    end
endmodule
